audio_record_ctrl: RTL and testbench
====================================

Name: audio_record_ctrl

Overview:
- Capture front end of the recorder path. Deserialises I2S left-channel samples from the codec ADC and drives the SRAM communicator's record-side interface: write-enable level, start pulse, reset pulse and data.
- Handles record, pause, resume and stop commands from the top-level control FSM.
- Stops recording when the SRAM communicator reports full.

Parameters:
- DATA_W, 16, sample width; bits shifted per left frame.
- SAMPLE_DIV, 1, store one of every SAMPLE_DIV left frames (1..15).
- CNT_W, 20, width of stored-sample counter; matches SRAM address width.

Ports:
- i_clk  in  1  codec bit clock (AUD_BCLK); the only clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_start  in  1  start (from IDLE) or resume (from PAUSE); level sampled each cycle.
- i_pause  in  1  pause request.
- i_stop  in  1  stop request.
- i_full  in  1  SRAM full, from SRAM communicator o_full.
- i_lrc  in  1  ADC LR clock (AUD_ADCLRCK); low = left channel.
- i_adc_dat  in  1  ADC serial data, MSB first.
- o_write  out  1  record mode level; to communicator i_write.
- o_sram_start  out  1  one-cycle store strobe.
- o_sram_reset  out  1  one-cycle address-reset strobe.
- o_sram_data  out  DATA_W  sample to store.
- o_state  out  2  0=IDLE, 1=REC, 2=PAUSE.
- o_sample_cnt  out  CNT_W  samples stored since last start; saturating.

Behaviour:
- Reset (sync, i_rst=1 at a clock edge): FSM=S_IDLE; all outputs 0; lrc_prev=0, bit_cnt=0, div_cnt=0, shift register 0.
- lrc_prev registers i_lrc every cycle. Frame start F is the cycle where lrc_prev=1 and i_lrc=0.
- Internal states and their o_state value:
  - S_IDLE: o_state 0.
  - S_ARM, S_SHIFT, S_STORE: o_state 1.
  - S_PAUSE: o_state 2.
- o_write=1 in every state except S_IDLE.
- Command priority each cycle: i_stop > i_full > i_pause > i_start.
- S_IDLE, i_start=1 at cycle t:
  - At t+1: S_ARM, o_write=1, o_sram_reset=1 for exactly cycle t+1.
  - o_sample_cnt and div_cnt cleared.
- S_ARM:
  - On frame start F: go to S_SHIFT; the I2S delay bit at F is discarded.
- S_SHIFT:
  - Samples i_adc_dat at F+1..F+16, shifting MSB first.
  - After the 16th bit, goes to S_STORE for cycle F+17.
  - A new frame start seen while in S_SHIFT restarts the shift: bit_cnt=0, partial sample discarded.
- S_STORE (one cycle):
  - o_sram_data loads the shift register and holds until the next store.
  - o_sram_start=1 iff div_cnt==0 and i_full=0.
  - div_cnt = (div_cnt+1) mod SAMPLE_DIV.
  - o_sample_cnt increments on each strobe and saturates at 2^CNT_W-1.
  - Next state: S_ARM.
- o_sram_start and o_sram_reset are never high in the same cycle.
- Strobe spacing is at least 32 cycles, which the communicator's 2-cycle write path tolerates.
- i_pause in S_ARM/S_SHIFT/S_STORE:
  - Next cycle S_PAUSE; partial sample discarded; no strobe in that cycle.
- S_PAUSE, i_start=1: go to S_ARM. No o_sram_reset; counters retained.
- i_stop in any non-IDLE state: S_IDLE next cycle, o_write=0. o_sample_cnt and o_sram_data hold.
- i_full=1 in any non-IDLE state: S_IDLE next cycle, and no strobe is issued.
- i_start while in a recording state: ignored.
- i_rst mid-capture: everything returns to reset values at the next edge.

Decomposition:
- Package audio_pkg holds:
  - rec_state_e enum {S_IDLE, S_ARM, S_SHIFT, S_STORE, S_PAUSE}.
  - o_state encodings REC_IDLE=0, REC_REC=1, REC_PAUSE=2.
  - I2S_DELAY=1.
- One sub-module, i2s_rx_shift: handles lrc edge detect, bit counter and shift register, and outputs frame_start and word_done. The FSM stays in audio_record_ctrl.

Test Plan:
- Reset then i_start=1 for one cycle -> next cycle o_sram_reset=1 (one cycle), o_write=1, o_state=1, o_sample_cnt=0.
- Serial left word 16'hA5C3 after lrc fall at cycle F -> o_sram_start=1 only at F+17, o_sram_data=16'hA5C3, o_sample_cnt=1. Right-channel bits never stored.
- SAMPLE_DIV=3 over 9 left frames -> exactly 3 strobes, on frames 1, 4, 7; o_sample_cnt=3.
- i_pause at F+8 -> no strobe for that frame, o_state=2, o_write=1. i_start later -> S_ARM with no o_sram_reset; the next frame stores and o_sample_cnt continues from its prior value.
- i_full=1 coincident with S_STORE -> no strobe, next cycle o_state=0, o_write=0. Simultaneous i_stop and i_pause -> o_state=0.
- i_rst=1 at F+10 -> next cycle all outputs 0, S_IDLE. A second lrc fall mid-shift -> capture restarts and the next strobe carries the new word only.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and encodings for the record-side capture path.
package audio_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SHIFT,
        S_STORE,
        S_PAUSE
    } rec_state_e;

    localparam logic [1:0] REC_IDLE  = 2'd0;
    localparam logic [1:0] REC_REC   = 2'd1;
    localparam logic [1:0] REC_PAUSE = 2'd2;

    // Bit clocks between the LR clock fall and the sample MSB.
    localparam int unsigned I2S_DELAY = 1;

    function automatic logic [1:0] state_code(input rec_state_e s);
        case (s)
            S_IDLE:  return REC_IDLE;
            S_PAUSE: return REC_PAUSE;
            default: return REC_REC;
        endcase
    endfunction

endpackage

// File: rtl/i2s_rx_shift.sv
// I2S left-channel deserialiser: detects the LR clock fall, tracks the bit
// position within the left half-frame and assembles one MSB-first word.
module i2s_rx_shift
    import audio_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_lrc,
    input  logic              i_adc_dat,
    output logic              frame_start,
    output logic              word_done,
    output logic [DATA_W-1:0] word
);

    localparam int unsigned POS_LAST = I2S_DELAY + DATA_W - 1;
    localparam int unsigned POS_W    = $clog2(POS_LAST + 2);

    logic                lrc_prev_q;
    logic [POS_W-1:0]    pos_q;
    logic [DATA_W-2:0]   shift_q;
    logic                in_window;

    assign frame_start = lrc_prev_q & ~i_lrc;

    // pos_q is the bit-clock index since the last fall; the fall cycle itself is
    // the delay slot and is never shifted. A fresh fall restarts the word.
    assign in_window = !frame_start
                       && (pos_q >= POS_W'(I2S_DELAY))
                       && (pos_q <= POS_W'(POS_LAST));
    assign word_done = in_window && (pos_q == POS_W'(POS_LAST));

    // Only DATA_W-1 bits are held; the final bit joins combinationally.
    assign word = {shift_q, i_adc_dat};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lrc_prev_q <= 1'b0;
            pos_q      <= '0;
            shift_q    <= '0;
        end else begin
            lrc_prev_q <= i_lrc;
            if (frame_start) begin
                pos_q <= POS_W'(1);
            end else if (pos_q <= POS_W'(POS_LAST)) begin
                pos_q <= pos_q + POS_W'(1);
            end
            if (in_window) begin
                shift_q <= word[DATA_W-2:0];
            end
        end
    end

endmodule

// File: rtl/audio_record_ctrl.sv
// Record-side controller: captures I2S left samples and drives the SRAM
// communicator write interface under record/pause/resume/stop control.
module audio_record_ctrl
    import audio_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned SAMPLE_DIV = 1,
    parameter int unsigned CNT_W      = 20
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_full,
    input  logic              i_lrc,
    input  logic              i_adc_dat,
    output logic              o_write,
    output logic              o_sram_start,
    output logic              o_sram_reset,
    output logic [DATA_W-1:0] o_sram_data,
    output logic [1:0]        o_state,
    output logic [CNT_W-1:0]  o_sample_cnt
);

    localparam int unsigned DIV_W = 4;

    rec_state_e         state_q, state_d;
    logic               sram_reset_q, sram_reset_d;
    logic [DATA_W-1:0]  data_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DIV_W-1:0]   div_q, div_next;

    logic               frame_start;
    logic               word_done;
    logic [DATA_W-1:0]  word;

    logic               load_data;
    logic               sram_start;
    logic               clr_cnt;
    logic               div_adv;

    i2s_rx_shift #(
        .DATA_W (DATA_W)
    ) u_rx (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_lrc       (i_lrc),
        .i_adc_dat   (i_adc_dat),
        .frame_start (frame_start),
        .word_done   (word_done),
        .word        (word)
    );

    assign div_next = (div_q == DIV_W'(SAMPLE_DIV - 1)) ? '0 : div_q + DIV_W'(1);

    // Commands resolve stop > full > pause > start; any abort also drops the
    // strobe that a coincident S_STORE would otherwise issue.
    always_comb begin
        state_d      = state_q;
        sram_reset_d = 1'b0;
        load_data    = 1'b0;
        sram_start   = 1'b0;
        clr_cnt      = 1'b0;
        div_adv      = 1'b0;
        if (state_q == S_IDLE) begin
            if (!i_stop && !i_full && !i_pause && i_start) begin
                state_d      = S_ARM;
                sram_reset_d = 1'b1;
                clr_cnt      = 1'b1;
            end
        end else if (i_stop || i_full) begin
            state_d = S_IDLE;
        end else if (i_pause) begin
            state_d = S_PAUSE;
        end else begin
            unique case (state_q)
                S_ARM: begin
                    if (frame_start) begin
                        state_d = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (word_done) begin
                        state_d   = S_STORE;
                        load_data = 1'b1;
                    end
                end
                S_STORE: begin
                    sram_start = (div_q == '0);
                    div_adv    = 1'b1;
                    state_d    = S_ARM;
                end
                S_PAUSE: begin
                    if (i_start) begin
                        state_d = S_ARM;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            sram_reset_q <= 1'b0;
            data_q       <= '0;
            cnt_q        <= '0;
            div_q        <= '0;
        end else begin
            state_q      <= state_d;
            sram_reset_q <= sram_reset_d;
            if (load_data) begin
                data_q <= word;
            end
            if (clr_cnt) begin
                cnt_q <= '0;
                div_q <= '0;
            end else begin
                if (sram_start && (cnt_q != '1)) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                if (div_adv) begin
                    div_q <= div_next;
                end
            end
        end
    end

    assign o_write      = (state_q != S_IDLE);
    assign o_sram_start = sram_start;
    assign o_sram_reset = sram_reset_q;
    assign o_sram_data  = data_q;
    assign o_state      = state_code(state_q);
    assign o_sample_cnt = cnt_q;

endmodule

// File: tb/tb_audio_record_ctrl.sv
// Bench for audio_record_ctrl: two instances (every frame stored, and one in
// three with a 2-bit counter) driven by the same I2S stream and commands.
module tb_audio_record_ctrl;
    import audio_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, start = 1'b0, pause = 1'b0, stop = 1'b0, full = 1'b0;
    logic lrc = 1'b1, dat = 1'b0;

    logic        w1, st1, rs1;
    logic [15:0] d1;
    logic [1:0]  s1;
    logic [19:0] c1;
    logic        w3, st3, rs3;
    logic [15:0] d3;
    logic [1:0]  s3;
    logic [1:0]  c3;

    audio_record_ctrl #(.DATA_W(16), .SAMPLE_DIV(1), .CNT_W(20)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_pause(pause), .i_stop(stop),
        .i_full(full), .i_lrc(lrc), .i_adc_dat(dat), .o_write(w1), .o_sram_start(st1),
        .o_sram_reset(rs1), .o_sram_data(d1), .o_state(s1), .o_sample_cnt(c1)
    );

    audio_record_ctrl #(.DATA_W(16), .SAMPLE_DIV(3), .CNT_W(2)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_pause(pause), .i_stop(stop),
        .i_full(full), .i_lrc(lrc), .i_adc_dat(dat), .o_write(w3), .o_sram_start(st3),
        .o_sram_reset(rs3), .o_sram_data(d3), .o_state(s3), .o_sample_cnt(c3)
    );

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [15:0] word;
        int          cnt1;
        int          cnt3;
    } vec_t;

    exp_t        q1[$];
    exp_t        q3[$];
    vec_t        tbl[10];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc_n = 0;
    int          m_cnt1 = 0, m_cnt3 = 0, m_d3 = 0;
    logic [15:0] last1 = '0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, required 'h%0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    task automatic mon(input bit sel, input logic st, input logic [15:0] d);
        exp_t e;
        int   n;
        n = sel ? q3.size() : q1.size();
        if (st === 1'b1) begin
            if (n == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_strobe dut%0d: strobe at cycle %0d data 'h%0h, required none",
                         sel ? 3 : 1, cyc_n, d);
            end else begin
                if (sel) e = q3.pop_front();
                else     e = q1.pop_front();
                chk(sel ? "strobe_cycle_div3" : "strobe_cycle", cyc_n, e.cyc);
                chk(sel ? "strobe_data_div3" : "strobe_data", d, e.data);
            end
        end else if (n > 0) begin
            if (sel) e = q3[0];
            else     e = q1[0];
            if (e.cyc <= cyc_n) begin
                if (sel) void'(q3.pop_front());
                else     void'(q1.pop_front());
                n_cmp++;
                n_err++;
                $display("FAIL missed_strobe dut%0d: no strobe at cycle %0d, required data 'h%0h",
                         sel ? 3 : 1, e.cyc, e.data);
            end
        end
    endtask

    // One bit clock: drive, observe strobes mid-cycle, advance past the edge.
    task automatic step(input logic l, input logic b);
        lrc = l;
        dat = b;
        @(negedge clk);
        mon(1'b0, st1, d1);
        mon(1'b1, st3, d3);
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic start_rec(input bit fresh);
        start = 1'b1;
        step(1'b1, 1'b0);
        start = 1'b0;
        chk("start_reset_pulse", rs1, fresh);
        chk("start_reset_pulse_div3", rs3, fresh);
        chk("start_state", s1, REC_REC);
        chk("start_write", w1, 1);
        if (fresh) begin
            chk("start_cnt_clear", c1, 0);
            m_cnt1 = 0;
            m_cnt3 = 0;
            m_d3   = 0;
        end else begin
            chk("resume_cnt_kept", c1, m_cnt1);
        end
        step(1'b1, 1'b0);
        chk("reset_pulse_width", rs1, 0);
    endtask

    // 64-cycle I2S frame: left word in bits 1..16 after the fall, random
    // elsewhere. ev_kind at cycle ev_at: 1 pause, 2 full, 4 reset.
    task automatic frame(input logic [15:0] w, input bit stores, input int ev_at,
                         input int ev_kind);
        exp_t e;
        logic l, b;
        for (int k = 0; k < 64; k++) begin
            l = (k >= 32);
            b = logic'($urandom_range(0, 1));
            if (k >= 1 && k <= 16) b = w[16-k];
            if (k == 0 && stores) begin
                e.data = w;
                e.cyc  = cyc_n + 17;
                q1.push_back(e);
                m_cnt1++;
                last1 = w;
                if (m_d3 == 0) begin
                    q3.push_back(e);
                    if (m_cnt3 < 3) m_cnt3++;
                end
                m_d3 = (m_d3 + 1) % 3;
            end
            if (k == ev_at) begin
                case (ev_kind)
                    1: pause = 1'b1;
                    2: full  = 1'b1;
                    4: rst   = 1'b1;
                    default: ;
                endcase
            end
            step(l, b);
            if (k == ev_at) begin
                pause = 1'b0;
                full  = 1'b0;
                rst   = 1'b0;
                case (ev_kind)
                    1: begin
                        chk("pause_state", s1, REC_PAUSE);
                        chk("pause_write", w1, 1);
                        chk("pause_state_div3", s3, REC_PAUSE);
                    end
                    2: begin
                        chk("full_state", s1, REC_IDLE);
                        chk("full_write", w1, 0);
                        chk("full_cnt_hold", c1, m_cnt1);
                    end
                    4: begin
                        chk("rst_state", s1, 0);
                        chk("rst_write", w1, 0);
                        chk("rst_start", st1, 0);
                        chk("rst_reset", rs1, 0);
                        chk("rst_data", d1, 0);
                        chk("rst_cnt", c1, 0);
                        chk("rst_state_div3", s3, 0);
                    end
                    default: ;
                endcase
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{16'hA5C3, 1, 1};
        tbl[1] = '{16'h1234, 2, 1};
        tbl[2] = '{16'hFFFF, 3, 1};
        tbl[3] = '{16'h0001, 4, 2};
        tbl[4] = '{16'h8000, 5, 2};
        tbl[5] = '{16'h5A5A, 6, 2};
        tbl[6] = '{16'h0F0F, 7, 3};
        tbl[7] = '{16'hC3A5, 8, 3};
        tbl[8] = '{16'h7E81, 9, 3};
        tbl[9] = '{16'hBEEF, 10, 3};

        @(posedge clk);
        #1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        rst = 1'b0;
        chk("reset_state", s1, REC_IDLE);
        chk("reset_write", w1, 0);
        chk("reset_start", st1, 0);
        chk("reset_sram_reset", rs1, 0);
        chk("reset_data", d1, 0);
        chk("reset_cnt", c1, 0);
        chk("reset_state_div3", s3, REC_IDLE);
        step(1'b1, 1'b0);

        start_rec(1'b1);
        for (int i = 0; i < 10; i++) begin
            frame(tbl[i].word, 1'b1, -1, 0);
            chk("tbl_cnt", c1, tbl[i].cnt1);
            chk("tbl_cnt_div3", c3, tbl[i].cnt3);
        end

        // Pause mid-word, resume, next frame continues the count.
        frame(16'h6B2D, 1'b0, 8, 1);
        start_rec(1'b0);
        frame(16'h9D4E, 1'b1, -1, 0);
        chk("resume_cnt", c1, m_cnt1);
        chk("resume_cnt_div3", c3, m_cnt3);

        // Stop and pause together: stop wins, count and data hold.
        stop  = 1'b1;
        pause = 1'b1;
        step(1'b1, 1'b0);
        stop  = 1'b0;
        pause = 1'b0;
        chk("stop_pause_state", s1, REC_IDLE);
        chk("stop_pause_state_div3", s3, REC_IDLE);
        chk("stop_write", w1, 0);
        chk("stop_write_div3", w3, 0);
        chk("stop_cnt_hold", c1, m_cnt1);
        chk("stop_data_hold", d1, last1);
        step(1'b1, 1'b0);

        // Full coincident with S_STORE suppresses the strobe.
        start_rec(1'b1);
        frame(16'h1357, 1'b0, 17, 2);

        // Reset mid-capture.
        start_rec(1'b1);
        frame(16'h2468, 1'b0, 10, 4);

        // Second LR fall mid-shift: only the new word is stored.
        start_rec(1'b1);
        for (int k = 0; k < 7; k++) step(1'b0, logic'($urandom_range(0, 1)));
        step(1'b1, logic'($urandom_range(0, 1)));
        frame(16'h3C5A, 1'b1, -1, 0);
        chk("restart_cnt", c1, 1);
        chk("restart_cnt_div3", c3, 1);
        chk("restart_data", d1, 16'h3C5A);

        for (int k = 0; k < 4; k++) step(1'b1, 1'b0);
        chk("queue_drained", q1.size(), 0);
        chk("queue_drained_div3", q3.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
